// File: rtl/risc_v_pkg.sv
// Shared fetch-path definitions: reset program counter, instruction size and
// the fetch FSM state type.
package risc_v_pkg;

    localparam logic [31:0] RESET_PC    = 32'h0040_0000;
    localparam int          INSTR_BYTES = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small buffer of fetched {pc, instruction} pairs between fetch and decode.
// Flush wins over push and pop, so a redirect discards everything at one edge.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    // Storage, pointers and occupancy; storage is cleared on reset so the
    // head reads zero until the first instruction lands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Head entry and status flags come straight from registered state.
    always_comb begin
        rdata = mem[rd_ptr];
        empty = (count == '0);
        full  = (count == CW'(DEPTH));
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC register, redirect handling and run/idle control,
// feeding a two-entry buffer that decode drains with a valid/ready handshake.
//
// state | meaning
// IDLE  | fetch disabled; PC held (redirects still retarget it)
// RUN   | fetching one instruction per cycle while buffer space allows
module instr_fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(risc_v_pkg::RESET_PC),
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_en,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rd,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [DATA_WIDTH-1:0] out_pc
);

    import risc_v_pkg::*;

    fetch_state_t            state;
    fetch_state_t            state_next;
    logic [DATA_WIDTH-1:0]   fetch_pc;
    logic                    push;
    logic                    pop;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic [2*DATA_WIDTH-1:0] fifo_rdata;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and buffer handshakes; redirect suppresses the push so the
    // word read at the stale PC is never buffered.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        push       = 1'b0;
        case (state)
            IDLE: if (fetch_en)  state_next = RUN;
            RUN:  if (!fetch_en) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        pop  = out_valid && out_ready;
        push = (state == RUN) && fetch_en && !redirect_valid && (!fifo_full || pop);
    end

    // PC register: redirect target (word aligned) beats sequential advance;
    // the add wraps naturally at the top of the address space.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[DATA_WIDTH-1:2], 2'b00};
        end else if (push) begin
            fetch_pc <= fetch_pc + DATA_WIDTH'(INSTR_BYTES);
        end
    end

    fetch_fifo #(
        .WIDTH (2 * DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata ({fetch_pc, imem_rd}),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Memory address and decode-side outputs, all from registered state.
    always_comb begin
        imem_addr = fetch_pc;
        out_valid = !fifo_empty;
        out_pc    = fifo_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
        out_instr = fifo_rdata[DATA_WIDTH-1:0];
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run,
// checked against a queue-based model of the fetch buffer.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int checks = 0;
    int passes = 0;

    // model state: buffered PCs (oldest first), next fetch PC, run flag
    logic [31:0] m_q[$];
    logic [31:0] m_pc;
    bit          m_run;
    logic [31:0] m_log[$];
    logic [31:0] d_log[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h3C5A, a[31:16] + 16'h1234};
    endfunction

    assign imem_rd = mem_word(imem_addr);

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_rd        (imem_rd),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    // One clock: log the DUT handshake, advance DUT and model, settle past the edge.
    task automatic tick();
        bit pop;
        bit push;
        #2;
        if (rst_n && out_valid && out_ready) d_log.push_back(out_pc);
        pop  = (m_q.size() > 0) && out_ready;
        push = m_run && fetch_en && !redirect_valid && ((m_q.size() < 2) || pop);
        @(posedge clk);
        if (!rst_n) begin
            m_q.delete();
            m_pc  = 32'h0040_0000;
            m_run = 1'b0;
        end else begin
            if (pop) m_log.push_back(m_q[0]);
            if (redirect_valid) begin
                m_q.delete();
                m_pc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (pop) void'(m_q.pop_front());
                if (push) begin
                    m_q.push_back(m_pc);
                    m_pc = m_pc + 32'd4;
                end
            end
            m_run = fetch_en;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; out_ready = 1'b0;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid actual=%b expected=0", out_valid); else passes++;
        checks++; if (out_pc !== 32'h0) $display("FAIL reset_out_pc actual=%h expected=0", out_pc); else passes++;
        checks++; if (out_instr !== 32'h0) $display("FAIL reset_out_instr actual=%h expected=0", out_instr); else passes++;
        checks++; if (imem_addr !== 32'h0040_0000) $display("FAIL reset_addr actual=%h expected=00400000", imem_addr); else passes++;
    endtask

    task automatic test_startup();
        rst_n = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
        tick();
        checks++; if (imem_addr !== 32'h0040_0000) $display("FAIL start_addr0 actual=%h expected=00400000", imem_addr); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL start_valid0 actual=%b expected=0", out_valid); else passes++;
        tick();
        checks++; if (imem_addr !== 32'h0040_0004) $display("FAIL start_addr1 actual=%h expected=00400004", imem_addr); else passes++;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0040_0000)
            $display("FAIL start_out0 actual=%b/%h expected=1/00400000", out_valid, out_pc); else passes++;
        checks++; if (out_instr !== mem_word(32'h0040_0000))
            $display("FAIL start_instr0 actual=%h expected=%h", out_instr, mem_word(32'h0040_0000)); else passes++;
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0040_0004)
            $display("FAIL start_out1 actual=%b/%h expected=1/00400004", out_valid, out_pc); else passes++;
        checks++; if (out_instr !== mem_word(32'h0040_0004))
            $display("FAIL start_instr1 actual=%h expected=%h", out_instr, mem_word(32'h0040_0004)); else passes++;
    endtask

    task automatic test_backpressure();
        fetch_en = 1'b1; out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i >= 2) begin
                checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0040_0000)
                    $display("FAIL bp_stable actual=%b/%h expected=1/00400000", out_valid, out_pc); else passes++;
            end
        end
        checks++; if (imem_addr !== 32'h0040_0008) $display("FAIL bp_addr_hold actual=%h expected=00400008", imem_addr); else passes++;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0040_0000 + 32'(4 * i))
                $display("FAIL bp_drain actual=%b/%h expected=1/%h", out_valid, out_pc, 32'h0040_0000 + 32'(4 * i)); else passes++;
            checks++; if (out_instr !== mem_word(32'h0040_0000 + 32'(4 * i)))
                $display("FAIL bp_drain_instr actual=%h expected=%h", out_instr, mem_word(32'h0040_0000 + 32'(4 * i))); else passes++;
            tick();
        end
    endtask

    task automatic test_redirect();
        fetch_en = 1'b1; out_ready = 1'b0;
        tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0040_0103;
        tick();
        redirect_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("FAIL redir_flush actual=%b expected=0", out_valid); else passes++;
        checks++; if (imem_addr !== 32'h0040_0100) $display("FAIL redir_addr actual=%h expected=00400100", imem_addr); else passes++;
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0040_0100)
            $display("FAIL redir_out actual=%b/%h expected=1/00400100", out_valid, out_pc); else passes++;
        checks++; if (out_instr !== mem_word(32'h0040_0100))
            $display("FAIL redir_instr actual=%h expected=%h", out_instr, mem_word(32'h0040_0100)); else passes++;
    endtask

    task automatic test_redirect_pop();
        int n0;
        fetch_en = 1'b1; out_ready = 1'b0;
        tick();
        n0 = d_log.size();
        redirect_valid = 1'b1; redirect_pc = 32'h0040_0200; out_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        checks++; if (d_log.size() != n0 + 1 || d_log[d_log.size()-1] !== 32'h0040_0100)
            $display("FAIL rp_head_once actual=%0d/%h expected=%0d/00400100", d_log.size() - n0, d_log[d_log.size()-1], 1); else passes++;
        checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h0040_0200)
            $display("FAIL rp_flush actual=%b/%h expected=0/00400200", out_valid, imem_addr); else passes++;
        tick(); tick();
        checks++; if (d_log[d_log.size()-1] !== 32'h0040_0200)
            $display("FAIL rp_resume actual=%h expected=00400200", d_log[d_log.size()-1]); else passes++;
        checks++; if (out_pc !== 32'h0040_0204)
            $display("FAIL rp_next actual=%h expected=00400204", out_pc); else passes++;
    endtask

    task automatic test_wrap();
        fetch_en = 1'b1; out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_target actual=%h expected=fffffffc", imem_addr); else passes++;
        tick();
        checks++; if (imem_addr !== 32'h0000_0000) $display("FAIL wrap_addr actual=%h expected=00000000", imem_addr); else passes++;
        checks++; if (out_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_out actual=%h expected=fffffffc", out_pc); else passes++;
        tick();
        checks++; if (out_pc !== 32'h0000_0000 || out_instr !== mem_word(32'h0))
            $display("FAIL wrap_out0 actual=%h/%h expected=00000000/%h", out_pc, out_instr, mem_word(32'h0)); else passes++;
    endtask

    task automatic test_mid_reset();
        fetch_en = 1'b1; out_ready = 1'b0;
        tick(); tick(); tick();
        checks++; if (out_valid !== 1'b1) $display("FAIL mr_prefill actual=%b expected=1", out_valid); else passes++;
        out_ready = 1'b1;
        do_reset();
        fetch_en = 1'b0;
        checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h0040_0000)
            $display("FAIL mr_flush actual=%b/%h expected=0/00400000", out_valid, imem_addr); else passes++;
        tick(); tick();
        checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h0040_0000)
            $display("FAIL mr_idle actual=%b/%h expected=0/00400000", out_valid, imem_addr); else passes++;
        fetch_en = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h0040_0000)
            $display("FAIL mr_wake actual=%b/%h expected=0/00400000", out_valid, imem_addr); else passes++;
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0040_0000)
            $display("FAIL mr_first actual=%b/%h expected=1/00400000", out_valid, out_pc); else passes++;
    endtask

    task automatic test_random();
        int bad;
        for (int i = 0; i < 400; i++) begin
            fetch_en       = ($urandom % 8) != 0;
            redirect_valid = ($urandom % 10) == 0;
            redirect_pc    = $urandom;
            out_ready      = ($urandom % 3) != 0;
            tick();
            checks++; if (imem_addr !== m_pc) $display("FAIL rnd_addr cyc=%0d actual=%h expected=%h", i, imem_addr, m_pc); else passes++;
            checks++; if (out_valid !== (m_q.size() != 0))
                $display("FAIL rnd_valid cyc=%0d actual=%b expected=%b", i, out_valid, m_q.size() != 0); else passes++;
            if (m_q.size() != 0) begin
                checks++; if (out_pc !== m_q[0] || out_instr !== mem_word(m_q[0]))
                    $display("FAIL rnd_head cyc=%0d actual=%h/%h expected=%h/%h", i, out_pc, out_instr, m_q[0], mem_word(m_q[0])); else passes++;
            end
        end
        bad = 0;
        if (d_log.size() != m_log.size()) bad = 1;
        else foreach (m_log[k]) if (d_log[k] !== m_log[k]) bad++;
        checks++; if (bad != 0) $display("FAIL accept_log actual=%0d entries expected=%0d entries, %0d differ", d_log.size(), m_log.size(), bad); else passes++;
    endtask

    initial begin
        m_pc = 32'h0040_0000;
        m_run = 1'b0;
        test_reset();
        test_startup();
        test_backpressure();
        test_redirect();
        test_redirect_pop();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
